// File: rtl/sysbus_mem_responder.sv
// Burst memory responder on the split request/response system bus: 8-beat line reads and writes.
// Optional macro MEMRESP_DELAY_EN inserts MEM_LATENCY wait cycles ahead of read data.
module sysbus_mem_responder #(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH  = 13,
  parameter int MEM_WORDS      = 1024,
  parameter int MEM_LATENCY    = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      bus_reqcyc,
  input  logic [BUS_DATA_WIDTH-1:0] bus_req,
  input  logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
  output logic                      bus_reqack,
  output logic                      bus_respcyc,
  output logic [BUS_DATA_WIDTH-1:0] bus_resp,
  output logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
  input  logic                      bus_respack
);

  localparam int AW = $clog2(MEM_WORDS);

  if (MEM_WORDS < 8 || (MEM_WORDS & (MEM_WORDS - 1)) != 0 || MEM_LATENCY < 1) begin : g_bad_cfg
    $error("sysbus_mem_responder: MEM_WORDS must be a power of two >= 8 and MEM_LATENCY >= 1");
  end

  typedef enum logic [2:0] {
    IDLE,
    ACK,
`ifdef MEMRESP_DELAY_EN
    DELAY,
`endif
    RDATA,
    WDATA,
    WRESP
  } state_t;

  state_t                     state_q, state_d;
  logic [2:0]                 beat_q, beat_d;
  logic [AW-1:0]              base_q, base_d;
  logic [BUS_TAG_WIDTH-1:0]   tag_q, tag_d;
  logic [AW-1:0]              idx;
  logic                       mem_we;
  logic [BUS_DATA_WIDTH-1:0]  mem_q [MEM_WORDS];

`ifdef MEMRESP_DELAY_EN
  localparam int CW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY + 1) : 1;
  logic [CW-1:0] cnt_q, cnt_d;
`endif

  // Line base keeps its low three bits clear so the beat can simply be OR-ed in.
  assign idx = base_q | AW'(beat_q);

  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    base_d      = base_q;
    tag_d       = tag_q;
`ifdef MEMRESP_DELAY_EN
    cnt_d       = cnt_q;
`endif
    mem_we      = 1'b0;
    bus_reqack  = 1'b0;
    bus_respcyc = 1'b0;
    bus_resp    = '0;
    bus_resptag = '0;
    case (state_q)
      IDLE: begin
        if (bus_reqcyc) begin
          base_d  = bus_req[AW+2:3] & ~AW'(7);
          tag_d   = bus_reqtag;
          state_d = ACK;
        end
      end
      ACK: begin
        bus_reqack = 1'b1;
        beat_d     = 3'd0;
        if (tag_q[12]) begin
`ifdef MEMRESP_DELAY_EN
          cnt_d   = CW'(MEM_LATENCY);
          state_d = DELAY;
`else
          state_d = RDATA;
`endif
        end else begin
          state_d = WDATA;
        end
      end
`ifdef MEMRESP_DELAY_EN
      DELAY: begin
        if (cnt_q == CW'(1)) begin
          state_d = RDATA;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
`endif
      RDATA: begin
        bus_respcyc = 1'b1;
        bus_resp    = mem_q[idx];
        bus_resptag = tag_q;
        if (bus_respack) begin
          beat_d = beat_q + 3'd1;
          if (beat_q == 3'd7) state_d = IDLE;
        end
      end
      WDATA: begin
        bus_reqack = bus_reqcyc;
        if (bus_reqcyc) begin
          mem_we = 1'b1;
          beat_d = beat_q + 3'd1;
          if (beat_q == 3'd7) state_d = WRESP;
        end
      end
      WRESP: begin
        bus_respcyc = 1'b1;
        bus_resptag = tag_q;
        if (bus_respack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      beat_q  <= '0;
      base_q  <= '0;
      tag_q   <= '0;
`ifdef MEMRESP_DELAY_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      base_q  <= base_d;
      tag_q   <= tag_d;
`ifdef MEMRESP_DELAY_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  // Storage deliberately outside the reset domain: contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[idx] <= bus_req;
  end

endmodule

// File: tb/tb_sysbus_mem_responder.sv
// Self-checking bench for sysbus_mem_responder: directed vector table, multi-cycle
// reset-abort sequences, and randomized bursts against a line-level memory model.
module tb_sysbus_mem_responder;

  localparam int DW          = 64;
  localparam int TW          = 13;
  localparam int MEM_WORDS   = 1024;
  localparam int MEM_LATENCY = 4;
  localparam int LINES       = MEM_WORDS / 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          bus_reqcyc = 1'b0;
  logic [DW-1:0] bus_req = '0;
  logic [TW-1:0] bus_reqtag = '0;
  logic          bus_reqack;
  logic          bus_respcyc;
  logic [DW-1:0] bus_resp;
  logic [TW-1:0] bus_resptag;
  logic          bus_respack = 1'b0;

  sysbus_mem_responder #(
    .BUS_DATA_WIDTH(DW),
    .BUS_TAG_WIDTH (TW),
    .MEM_WORDS     (MEM_WORDS),
    .MEM_LATENCY   (MEM_LATENCY)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .bus_reqcyc (bus_reqcyc),
    .bus_req    (bus_req),
    .bus_reqtag (bus_reqtag),
    .bus_reqack (bus_reqack),
    .bus_respcyc(bus_respcyc),
    .bus_resp   (bus_resp),
    .bus_resptag(bus_resptag),
    .bus_respack(bus_respack)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] model_mem [MEM_WORDS];
  bit            written   [LINES];

  typedef struct {
    bit            rd;
    logic [63:0]   addr;
    logic [TW-1:0] tag;
    logic [63:0]   base;       // expected (read) or driven (write) data of beat 0; beat i = base+i
    int            stall_beat;
    int            stall_len;
    bit            hold;
    int            abort_beat; // 8 = no abort
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int line_of(input logic [63:0] addr);
    return int'((addr >> 6) % LINES);
  endfunction

  task automatic idle_chk(input string who);
    chk({who, "_reqack"}, 64'(bus_reqack), 64'd0);
    chk({who, "_respcyc"}, 64'(bus_respcyc), 64'd0);
    chk({who, "_resp"}, bus_resp, 64'd0);
    chk({who, "_resptag"}, 64'(bus_resptag), 64'd0);
  endtask

  // Entered at a negedge; leaves at the negedge of the first cycle after the ack cycle.
  task automatic accept(input logic [63:0] addr, input logic [TW-1:0] tag, input bit hold);
    bus_reqcyc = 1'b1;
    bus_req    = addr;
    bus_reqtag = tag;
    @(posedge clk); @(negedge clk);
    chk("ack_reqack", 64'(bus_reqack), 64'd1);
    chk("ack_respcyc", 64'(bus_respcyc), 64'd0);
    if (!hold) bus_reqcyc = 1'b0;
    @(posedge clk); @(negedge clk);
  endtask

  task automatic write_line(input logic [63:0] addr, input logic [TW-1:0] tag,
                            input logic [63:0] w [8], input int stall_pct, input int abort_after);
    int l;
    l = line_of(addr);
    accept(addr, tag, 1'b0);
    for (int b = 0; b < 8; b++) begin
      if (b == abort_after) begin
        bus_reqcyc = 1'b0;
        reset = 1'b1;
        #1;
        idle_chk("wr_abort");
        @(posedge clk); @(negedge clk);
        reset = 1'b0;
        return;
      end
      for (int s = 0; s < 3; s++) begin
        if (int'($urandom_range(99)) >= stall_pct) break;
        bus_reqcyc = 1'b0;
        #1;
        chk("wr_stall_reqack", 64'(bus_reqack), 64'd0);
        @(posedge clk); @(negedge clk);
      end
      bus_reqcyc = 1'b1;
      bus_req    = w[b];
      #1;
      chk("wr_reqack", 64'(bus_reqack), 64'd1);
      chk("wr_respcyc", 64'(bus_respcyc), 64'd0);
      @(posedge clk);
      model_mem[l*8 + b] = w[b];
      @(negedge clk);
    end
    bus_reqcyc = 1'b0;
    #1;
    chk("wresp_respcyc", 64'(bus_respcyc), 64'd1);
    chk("wresp_resp", bus_resp, 64'd0);
    chk("wresp_tag", 64'(bus_resptag), 64'(tag));
    chk("wresp_reqack", 64'(bus_reqack), 64'd0);
    if ($urandom_range(1) == 1) begin
      @(posedge clk); @(negedge clk);
      chk("wresp_wait_respcyc", 64'(bus_respcyc), 64'd1);
    end
    bus_respack = 1'b1;
    @(posedge clk); @(negedge clk);
    bus_respack = 1'b0;
    chk("wresp_done_respcyc", 64'(bus_respcyc), 64'd0);
    written[l] = 1'b1;
  endtask

  task automatic read_line(input logic [63:0] addr, input logic [TW-1:0] tag,
                           input logic [63:0] exp [8], input int stall_beat, input int stall_len,
                           input int abort_beat, input bit hold);
    accept(addr, tag, hold);
`ifdef MEMRESP_DELAY_EN
    for (int i = 0; i < MEM_LATENCY; i++) begin
      chk("delay_respcyc", 64'(bus_respcyc), 64'd0);
      chk("delay_reqack", 64'(bus_reqack), 64'd0);
      @(posedge clk); @(negedge clk);
    end
`endif
    for (int b = 0; b < 8; b++) begin
      chk("rd_respcyc", 64'(bus_respcyc), 64'd1);
      chk("rd_data", bus_resp, exp[b]);
      chk("rd_tag", 64'(bus_resptag), 64'(tag));
      chk("rd_reqack", 64'(bus_reqack), 64'd0);
      if (b == abort_beat) begin
        reset = 1'b1;
        bus_reqcyc = 1'b0;
        #1;
        idle_chk("rd_abort");
        @(posedge clk); @(negedge clk);
        reset = 1'b0;
        return;
      end
      if (b == stall_beat) begin
        for (int s = 0; s < stall_len; s++) begin
          bus_respack = 1'b0;
          @(posedge clk); @(negedge clk);
          chk("rd_stall_data", bus_resp, exp[b]);
          chk("rd_stall_respcyc", 64'(bus_respcyc), 64'd1);
        end
      end
      bus_respack = 1'b1;
      @(posedge clk); @(negedge clk);
      bus_respack = 1'b0;
    end
    chk("rd_end_respcyc", 64'(bus_respcyc), 64'd0);
    chk("rd_end_reqack", 64'(bus_reqack), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] w [8];
    logic [63:0] e [8];
    logic [63:0] addr;
    logic [63:0] mask;
    logic [TW-1:0] tag;
    int l;

    vecs[0] = '{1'b0, 64'h1000, 13'h0042, 64'hA0,   8, 0, 1'b0, 8};
    vecs[1] = '{1'b1, 64'h1000, 13'h1100, 64'hA0,   8, 0, 1'b0, 8};
    vecs[2] = '{1'b1, 64'h1038, 13'h1001, 64'hA0,   8, 0, 1'b0, 8};
    vecs[3] = '{1'b1, 64'h1000 + MEM_WORDS*8, 13'h1002, 64'hA0, 8, 0, 1'b0, 8};
    vecs[4] = '{1'b0, 64'h1240, 13'h0003, 64'h5500, 8, 0, 1'b0, 8};
    vecs[5] = '{1'b1, 64'h1240, 13'h1004, 64'h5500, 2, 5, 1'b0, 8};
    vecs[6] = '{1'b1, 64'h1240, 13'h1FFF, 64'h5500, 8, 0, 1'b1, 8};
    vecs[7] = '{1'b1, 64'h1240, 13'h1FFF, 64'h5500, 8, 0, 1'b0, 8};
    vecs[8] = '{1'b1, 64'h1000, 13'h1005, 64'hA0,   8, 0, 1'b0, 3};
    vecs[9] = '{1'b1, 64'h1000, 13'h1006, 64'hA0,   8, 0, 1'b0, 8};

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    idle_chk("reset");
    reset = 1'b0;

    // Directed vectors (write stalls disabled so timing is fixed).
    foreach (vecs[i]) begin
      for (int b = 0; b < 8; b++) begin
        w[b] = vecs[i].base + 64'(b);
      end
      if (vecs[i].rd) read_line(vecs[i].addr, vecs[i].tag, w, vecs[i].stall_beat,
                                vecs[i].stall_len, vecs[i].abort_beat, vecs[i].hold);
      else            write_line(vecs[i].addr, vecs[i].tag, w, 0, 8);
    end

    // Write aborted by reset after three beats: those stick, the rest keep old data.
    for (int b = 0; b < 8; b++) w[b] = 64'h7700 + 64'(b);
    write_line(64'h1240, 13'h0007, w, 0, 3);
    repeat (2) begin
      idle_chk("post_wr_abort");
      @(posedge clk); @(negedge clk);
    end
    for (int b = 0; b < 8; b++) e[b] = (b < 3) ? 64'h7700 + 64'(b) : 64'h5500 + 64'(b);
    read_line(64'h1240, 13'h1008, e, 8, 0, 8, 1'b0);

    // Response acknowledge while idle must be ignored.
    bus_respack = 1'b1;
    @(posedge clk); @(negedge clk);
    idle_chk("idle_respack");
    bus_respack = 1'b0;

    // Randomized bursts against the line model.
    mask = ~(64'(LINES - 1) << 6);
    for (int n = 0; n < 40; n++) begin
      l = ($urandom_range(7) * 37) % LINES;
      addr = ({$urandom(), $urandom()} & mask) | (64'(l) << 6);
      if ($urandom_range(1) == 1 && written[l]) begin
        tag = {1'b1, 12'($urandom())};
        for (int b = 0; b < 8; b++) e[b] = model_mem[l*8 + b];
        read_line(addr, tag, e, int'($urandom_range(8)), int'($urandom_range(3)), 8, 1'b0);
      end else begin
        tag = {1'b0, 12'($urandom())};
        for (int b = 0; b < 8; b++) w[b] = {$urandom(), $urandom()};
        write_line(addr, tag, w, 30, 8);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
